// File: rtl/load_store_unit.sv
// Multi-cycle data-memory access stage: issues one req/ready bus transaction per
// load or store, stalls the core meanwhile, and returns lane-extracted, extended load data.
module load_store_unit #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [2:0]  Size,
    input  logic [31:0] Addr,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        Stall,
    output logic        MisalignFault,
    output logic        BusError,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready
);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    typedef enum logic [1:0] {
        W_WORD,
        W_HALF,
        W_BYTE
    } width_t;

    localparam logic [7:0] LAST_COUNT = 8'(TIMEOUT - 1);

    state_t      state;
    state_t      next_state;
    logic [7:0]  count;
    logic [2:0]  acc_size;
    logic [1:0]  acc_lo;

    logic        valid;
    logic        misaligned;
    width_t      width;
    logic        issue;
    logic        complete;
    logic        abort;
    logic [3:0]  be_next;
    logic [31:0] wdata_next;

    // Codes 101-111 fall into the word default on purpose.
    function automatic width_t size_width(input logic [2:0] code);
        case (code)
            3'b001, 3'b010: return W_HALF;
            3'b011, 3'b100: return W_BYTE;
            default:        return W_WORD;
        endcase
    endfunction

    function automatic logic [31:0] extract_lane(input logic [31:0] data,
                                                 input logic [2:0]  code,
                                                 input logic [1:0]  lo);
        logic [7:0]  lane_b;
        logic [15:0] lane_h;
        logic        sgn;
        lane_b = data[{lo, 3'b000} +: 8];
        lane_h = lo[1] ? data[31:16] : data[15:0];
        sgn    = (code == 3'b001) || (code == 3'b011);
        case (size_width(code))
            W_BYTE:  return {{24{sgn & lane_b[7]}}, lane_b};
            W_HALF:  return {{16{sgn & lane_h[15]}}, lane_h};
            default: return data;
        endcase
    endfunction

    assign valid      = MemRead | MemWrite;
    assign width      = size_width(Size);
    assign misaligned = ((width == W_WORD) && (Addr[1:0] != 2'b00)) ||
                        ((width == W_HALF) && Addr[0]);

    // NOTE: every signal written below gets a default first, so no path can infer a latch.
    always_comb begin
        be_next    = 4'b1111;
        wdata_next = WriteData;
        case (width)
            W_BYTE: begin
                be_next    = 4'b0001 << Addr[1:0];
                wdata_next = {4{WriteData[7:0]}};
            end
            W_HALF: begin
                be_next    = Addr[1] ? 4'b1100 : 4'b0011;
                wdata_next = {2{WriteData[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        next_state = state;
        issue      = 1'b0;
        complete   = 1'b0;
        abort      = 1'b0;
        case (state)
            IDLE: begin
                if (valid && !misaligned) begin
                    issue      = 1'b1;
                    next_state = BUSY;
                end
            end
            BUSY: begin
                if (mem_ready) begin
                    complete   = 1'b1;
                    next_state = DONE;
                end else if (count == LAST_COUNT) begin
                    abort      = 1'b1;
                    next_state = DONE;
                end
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    assign Stall         = ((state == IDLE) && valid && !misaligned) || (state == BUSY);
    assign MisalignFault = (state == IDLE) && valid && misaligned;

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count     <= '0;
            acc_size  <= '0;
            acc_lo    <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_be    <= '0;
            mem_wdata <= '0;
            ReadData  <= '0;
            BusError  <= 1'b0;
        end else begin
            BusError <= abort;
            if (issue) begin
                count     <= '0;
                acc_size  <= Size;
                acc_lo    <= Addr[1:0];
                mem_req   <= 1'b1;
                mem_we    <= MemWrite;
                mem_addr  <= {Addr[31:2], 2'b00};
                mem_be    <= be_next;
                mem_wdata <= wdata_next;
            end
            if (complete) begin
                mem_req <= 1'b0;
                if (!mem_we) begin
                    ReadData <= extract_lane(mem_rdata, acc_size, acc_lo);
                end
            end else if (abort) begin
                mem_req  <= 1'b0;
                ReadData <= '0;
            end else if (state == BUSY) begin
                count <= count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed cases plus randomized accesses
// against an arithmetic reference model of the access rules.
module tb_load_store_unit;

    localparam int TB_TIMEOUT = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemRead;
    logic        MemWrite;
    logic [2:0]  Size;
    logic [31:0] Addr;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic        Stall;
    logic        MisalignFault;
    logic        BusError;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_rd   = '0;

    load_store_unit #(.TIMEOUT(TB_TIMEOUT)) dut (
        .clk           (clk),
        .reset         (reset),
        .MemRead       (MemRead),
        .MemWrite      (MemWrite),
        .Size          (Size),
        .Addr          (Addr),
        .WriteData     (WriteData),
        .ReadData      (ReadData),
        .Stall         (Stall),
        .MisalignFault (MisalignFault),
        .BusError      (BusError),
        .mem_req       (mem_req),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_be        (mem_be),
        .mem_wdata     (mem_wdata),
        .mem_rdata     (mem_rdata),
        .mem_ready     (mem_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
        end
    endtask

    // One core instruction: present it in IDLE, play the memory side with `waits`
    // wait cycles (waits >= TB_TIMEOUT never answers), and check every cycle.
    task automatic access(input bit rd, input bit wr, input logic [2:0] sz,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input int waits, input logic [31:0] rdata);
        int          nbytes;
        bit          sgn;
        bit          valid;
        bit          mis;
        bit          timed_out;
        int          lo;
        logic [3:0]  ebe;
        logic [31:0] ewd;
        logic [31:0] lane;

        case (sz)
            3'b001: begin nbytes = 2; sgn = 1'b1; end
            3'b010: begin nbytes = 2; sgn = 1'b0; end
            3'b011: begin nbytes = 1; sgn = 1'b1; end
            3'b100: begin nbytes = 1; sgn = 1'b0; end
            default: begin nbytes = 4; sgn = 1'b0; end
        endcase
        valid     = rd || wr;
        lo        = int'(addr[1:0]);
        mis       = valid && ((lo % nbytes) != 0);
        timed_out = waits >= TB_TIMEOUT;
        ebe       = 4'(((1 << nbytes) - 1) << lo);
        if (nbytes == 1)      ewd = 32'(wd[7:0]) * 32'h0101_0101;
        else if (nbytes == 2) ewd = 32'(wd[15:0]) * 32'h0001_0001;
        else                  ewd = wd;

        @(negedge clk);
        MemRead   = rd;
        MemWrite  = wr;
        Size      = sz;
        Addr      = addr;
        WriteData = wd;
        mem_ready = 1'b0;
        #1;
        check("stall_issue", 32'(Stall), 32'(valid && !mis));
        check("misalign", 32'(MisalignFault), 32'(mis));
        check("buserr_idle", 32'(BusError), 32'd0);

        if (!valid || mis) begin
            @(negedge clk);
            MemRead  = 1'b0;
            MemWrite = 1'b0;
            #1;
            check("no_req", 32'(mem_req), 32'd0);
            check("rd_hold_idle", ReadData, exp_rd);
            return;
        end

        for (int b = 0; b < TB_TIMEOUT; b++) begin
            @(negedge clk);
            #1;
            check("req_busy", 32'(mem_req), 32'd1);
            check("stall_busy", 32'(Stall), 32'd1);
            check("we", 32'(mem_we), 32'(wr));
            check("addr", mem_addr, addr & 32'hFFFF_FFFC);
            check("be", 32'(mem_be), 32'(ebe));
            check("wdata", mem_wdata, ewd);
            if (b == waits) begin
                mem_ready = 1'b1;
                mem_rdata = rdata;
                break;
            end
            mem_ready = 1'b0;
            mem_rdata = $urandom;
        end

        if (timed_out) begin
            exp_rd = '0;
        end else if (!wr) begin
            lane = rdata >> (8 * lo);
            if (nbytes == 1) begin
                lane = lane & 32'h0000_00FF;
                if (sgn && lane[7]) lane = lane | 32'hFFFF_FF00;
            end else if (nbytes == 2) begin
                lane = lane & 32'h0000_FFFF;
                if (sgn && lane[15]) lane = lane | 32'hFFFF_0000;
            end
            exp_rd = lane;
        end

        @(negedge clk);
        mem_ready = 1'b0;
        mem_rdata = $urandom;
        #1;
        check("stall_done", 32'(Stall), 32'd0);
        check("req_done", 32'(mem_req), 32'd0);
        check("buserr_done", 32'(BusError), 32'(timed_out));
        check("readdata", ReadData, exp_rd);
        MemRead  = 1'b0;
        MemWrite = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset     = 1'b1;
        MemRead   = 1'b0;
        MemWrite  = 1'b0;
        Size      = 3'b000;
        Addr      = '0;
        WriteData = '0;
        mem_rdata = '0;
        mem_ready = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_req", 32'(mem_req), 32'd0);
        check("rst_stall", 32'(Stall), 32'd0);
        check("rst_be", 32'(mem_be), 32'd0);
        check("rst_wdata", mem_wdata, 32'd0);
        check("rst_readdata", ReadData, 32'd0);
        check("rst_buserr", 32'(BusError), 32'd0);
        reset = 1'b0;

        access(1'b1, 1'b0, 3'b000, 32'h0000_0100, 32'h0, 0, 32'hDEAD_BEEF);
        access(1'b1, 1'b0, 3'b011, 32'h0000_0203, 32'h0, 0, 32'h8011_2233);
        access(1'b1, 1'b0, 3'b100, 32'h0000_0203, 32'h0, 1, 32'h8011_2233);
        access(1'b0, 1'b1, 3'b001, 32'h0000_0042, 32'h1234_ABCD, 3, 32'h5555_5555);
        access(1'b1, 1'b0, 3'b000, 32'h0000_0101, 32'h0, 0, 32'h1111_1111);
        access(1'b1, 1'b1, 3'b011, 32'h0000_0011, 32'h0000_00A5, 2, 32'h7777_7777);
        access(1'b1, 1'b0, 3'b001, 32'h0000_0022, 32'h0, 0, 32'h8001_7FFF);

        // Reset during the second BUSY cycle abandons the access.
        @(negedge clk);
        MemRead = 1'b1;
        Size    = 3'b000;
        Addr    = 32'h0000_0300;
        @(negedge clk);
        mem_ready = 1'b0;
        @(negedge clk);
        reset   = 1'b1;
        MemRead = 1'b0;
        @(negedge clk);
        #1;
        exp_rd = '0;
        check("midrst_req", 32'(mem_req), 32'd0);
        check("midrst_stall", 32'(Stall), 32'd0);
        check("midrst_readdata", ReadData, exp_rd);
        check("midrst_be", 32'(mem_be), 32'd0);
        reset = 1'b0;
        access(1'b1, 1'b0, 3'b000, 32'h0000_0304, 32'h0, 1, 32'hCAFE_F00D);

        access(1'b1, 1'b0, 3'b000, 32'h0000_0400, 32'h0, 99, 32'h0);

        for (int i = 0; i < 300; i++) begin
            bit          rd;
            bit          wr;
            logic [31:0] a;
            int          sel;
            sel = $urandom_range(0, 7);
            rd  = (sel != 0) && (sel != 1) && (sel < 6);
            wr  = (sel == 1) || (sel >= 5);
            a   = $urandom;
            if ($urandom_range(0, 1) == 0) a = a & 32'hFFFF_FFFC;
            access(rd, wr, 3'($urandom_range(0, 7)), a, $urandom,
                   $urandom_range(0, TB_TIMEOUT), $urandom);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Multi-cycle data-memory access stage downstream of the control decoder in the RV32I core. It consumes the decoded MemWrite, load indication and 3-bit Size code together with the ALU address and rs2 data. It drives a req/ready data-memory bus with byte enables, and returns a lane-extracted, sign- or zero-extended ReadData to the writeback mux. It stalls the core for the duration of each access, and flags misaligned and timed-out accesses.

## Interface
- TIMEOUT, 16: number of BUSY cycles with mem_ready low after which the access is aborted (range 2..255).
- clk  in  1  core clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high reset.
- MemRead  in  1  load request (datapath drives ResultSrc==2'b01).
- MemWrite  in  1  store request from the control decoder.
- Size  in  3  access-size code: 000 word, 001 half signed, 010 half unsigned, 011 byte signed, 100 byte unsigned; 101–111 are treated as word.
- Addr  in  32  byte address (ALU result).
- WriteData  in  32  store data (rs2).
- ReadData  out  32  extended load result.
- Stall  out  1  holds PC and pipeline registers while high.
- MisalignFault  out  1  one-cycle pulse on a misaligned access.
- BusError  out  1  one-cycle pulse on timeout.
- mem_req  out  1  bus request.
- mem_we  out  1  1 = write.
- mem_addr  out  32  word address: {Addr[31:2],2'b00}.
- mem_be  out  4  byte enables.
- mem_wdata  out  32  lane-replicated store data.
- mem_rdata  in  32  read data, valid when mem_ready=1.
- mem_ready  in  1  access complete.

## Operation
- States: IDLE, BUSY, DONE.
- IDLE
  - An access is valid when MemRead|MemWrite. If both are high, the access is a write.
  - Misaligned: word with Addr[1:0]≠0, or half with Addr[0]≠0.
  - On a misaligned access: no bus request, MisalignFault=1 that cycle, Stall=0, stay IDLE, ReadData unchanged.
  - On a valid aligned access: register mem_we, mem_addr, mem_be, mem_wdata, Size and Addr[1:0]; set mem_req; go BUSY; clear the timeout counter.
- Byte enables and store data
  - Byte: mem_be = 4'b0001<<Addr[1:0], mem_wdata = {4{WriteData[7:0]}}.
  - Half: mem_be = Addr[1] ? 4'b1100 : 4'b0011, mem_wdata = {2{WriteData[15:0]}}.
  - Word: mem_be = 4'b1111, mem_wdata = WriteData.
  - Reads drive the same mem_be.
- BUSY
  - If mem_ready: mem_req←0. For a read, ReadData← the extracted lane (byte lane Addr[1:0] or half lane Addr[1]), sign-extended for codes 001/011 and zero-extended for 010/100. Go DONE.
  - Else increment the counter. When it reaches TIMEOUT-1: mem_req←0, ReadData←0, BusError←1, go DONE.
- DONE: Stall=0, BusError held for this cycle only, unconditionally go IDLE. The core retires the instruction on this edge, and the same instruction is not re-issued.
- Stores leave ReadData unchanged. ReadData holds its value until the next completed load or timeout.
- Stall = (IDLE & valid & aligned) | BUSY; Stall is combinational.
- Reset (including mid-access): state IDLE, counter 0. All outputs go to 0 on the next edge: mem_req, mem_we, mem_addr, mem_be, mem_wdata, ReadData, BusError, MisalignFault(comb)=0. The pending access is abandoned.

## Timing
- Cycle 0, IDLE, access presented: Stall=1.
- Cycle 1: mem_req=1; bus signals are stable and held until mem_ready is sampled high.
- Cycle 1+k: mem_ready sampled high (k≥0 wait cycles).
- Cycle 2+k: DONE, ReadData valid, Stall=0, mem_req=0.
- Zero-wait memory: 3 cycles per access, 2 stall cycles.
- Timeout: DONE is entered TIMEOUT cycles after the first mem_req cycle.
- mem_ready is ignored in IDLE and DONE.
- MisalignFault is combinational from IDLE inputs. BusError is registered.

## Test plan
- LW, zero-wait: Addr=0x100, mem_rdata=0xDEADBEEF with ready in the first req cycle → mem_addr=0x100, mem_be=1111. Stall high for 2 cycles; ReadData=0xDEADBEEF in DONE.
- LB/LBU at Addr=0x203, mem_rdata=0x80112233 → mem_be=1000. LB gives ReadData=0xFFFFFF80; LBU gives 0x00000080.
- SH at Addr=0x42, WriteData=0x1234ABCD, 3 wait cycles → mem_we=1, mem_be=1100, mem_wdata=0xABCDABCD held 4 cycles. Stall low in cycle 5; ReadData unchanged.
- LW at Addr=0x101 → MisalignFault=1 for one cycle, mem_req stays 0, Stall=0.
- TIMEOUT=4, mem_ready tied low → mem_req high for 4 cycles, then BusError=1 for one cycle, ReadData=0, back to IDLE.
- Reset asserted in the second BUSY cycle → next edge: mem_req=0, Stall=0, state IDLE. A following LW completes normally.
